// File: rtl/sram_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM between a fetch (read-only) and a data requester.
// Optional partial-write (read-modify-write) support is enabled by defining SRAM_ARB_RMW_EN.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [31:0]           i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [3:0]            d_req_be,
  input  logic [31:0]           d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [2:0] {IDLE, WR, RD, RSP, MRG} state_t;

  state_t state;
  logic   last_i;      // 1 when the fetch port won last, so data wins the next conflict
  logic   owner_d_p1;  // in-flight read belongs to the data port

`ifdef SRAM_ARB_RMW_EN
  localparam int LANE_W = DATA_WIDTH / 4;

  logic                  rmw_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [3:0]            be_p1;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = rdata;
    for (int k = 0; k < 4; k++)
      if (be[k]) merged[k*LANE_W +: LANE_W] = wdata[k*LANE_W +: LANE_W];
    return merged;
  endfunction

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[31:ADDR_WIDTH+2], i_req_addr[1:0],
                              d_req_addr[31:ADDR_WIDTH+2], d_req_addr[1:0]};
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[31:ADDR_WIDTH+2], i_req_addr[1:0],
                              d_req_addr[31:ADDR_WIDTH+2], d_req_addr[1:0], d_req_be};
`endif

  // Grants are combinational from the valids; suppressed during reset
  always_comb begin
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    if (rst_n && state == IDLE) begin
      if (d_req_valid && (!i_req_valid || last_i)) d_req_ready = 1'b1;
      else if (i_req_valid)                         i_req_ready = 1'b1;
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_i      <= 1'b1;
      owner_d_p1  <= 1'b0;
      csb0        <= 1'b1;
      web0        <= 1'b1;
      addr0       <= '0;
      din0        <= '0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_rdata <= '0;
      d_rsp_rdata <= '0;
`ifdef SRAM_ARB_RMW_EN
      rmw_p1      <= 1'b0;
      wdata_p1    <= '0;
      be_p1       <= '0;
`endif
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      csb0        <= 1'b1;
      web0        <= 1'b1;
      case (state)
        IDLE: begin
          if (d_req_ready) begin
            last_i     <= 1'b0;
            owner_d_p1 <= 1'b1;
            addr0      <= d_req_addr[ADDR_WIDTH+1:2];
`ifdef SRAM_ARB_RMW_EN
            wdata_p1   <= d_req_wdata;
            be_p1      <= d_req_be;
            rmw_p1     <= d_req_we && d_req_be != 4'b1111 && d_req_be != 4'b0000;
            if (d_req_we && (d_req_be == 4'b1111 || d_req_be == 4'b0000)) begin
              // An empty byte mask still answers but leaves the SRAM untouched
              state       <= WR;
              csb0        <= (d_req_be == 4'b0000);
              web0        <= (d_req_be == 4'b0000);
              din0        <= d_req_wdata;
              d_rsp_valid <= 1'b1;
              d_rsp_rdata <= '0;
            end else begin
              state <= RD;
              csb0  <= 1'b0;
            end
`else
            if (d_req_we) begin
              state       <= WR;
              csb0        <= 1'b0;
              web0        <= 1'b0;
              din0        <= d_req_wdata;
              d_rsp_valid <= 1'b1;
              d_rsp_rdata <= '0;
            end else begin
              state <= RD;
              csb0  <= 1'b0;
            end
`endif
          end else if (i_req_ready) begin
            last_i     <= 1'b1;
            owner_d_p1 <= 1'b0;
            addr0      <= i_req_addr[ADDR_WIDTH+1:2];
            state      <= RD;
            csb0       <= 1'b0;
`ifdef SRAM_ARB_RMW_EN
            rmw_p1     <= 1'b0;
`endif
          end
        end
        RD: begin
`ifdef SRAM_ARB_RMW_EN
          if (rmw_p1) begin
            state       <= MRG;
            csb0        <= 1'b0;
            web0        <= 1'b0;
            din0        <= byte_merge(wdata_p1, dout0, be_p1);
            d_rsp_valid <= 1'b1;
            d_rsp_rdata <= '0;
          end else begin
            state <= RSP;
            if (owner_d_p1) begin
              d_rsp_valid <= 1'b1;
              d_rsp_rdata <= dout0;
            end else begin
              i_rsp_valid <= 1'b1;
              i_rsp_rdata <= dout0;
            end
          end
`else
          state <= RSP;
          if (owner_d_p1) begin
            d_rsp_valid <= 1'b1;
            d_rsp_rdata <= dout0;
          end else begin
            i_rsp_valid <= 1'b1;
            i_rsp_rdata <= dout0;
          end
`endif
        end
        WR, RSP, MRG: state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: reset, directed vector table, corner sequences and a
// randomized run against a transaction-level reference model with a behavioural SRAM.
module tb_sram_arbiter;

  logic        clk0 = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [3:0]  d_req_be;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic        csb0, web0;
  logic [9:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk0 = ~clk0;

  sram_arbiter dut (
    .clk0(clk0), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_be(d_req_be), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  // Behavioural single-port SRAM, operating on the falling edge
  logic [31:0] sram [0:1023];
  initial for (int k = 0; k < 1024; k++) sram[k] = '0;
  always @(negedge clk0) begin
    if (!csb0) begin
      if (!web0) sram[addr0] <= din0;
      else       dout0 <= sram[addr0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_be = 4'hF; d_req_addr = '0; d_req_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          kind;      // 0 single-cycle write, 1 read, 2 read-modify-write
    logic        exp_csb;   // csb0 in the cycle after acceptance
    logic        exp_web;
    logic [31:0] exp_word;  // din0 for writes / merge, returned data for reads
  } vec_t;

  function automatic vec_t mk(input logic is_d, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata, input int kind,
                              input logic exp_csb, input logic exp_web, input logic [31:0] exp_word);
    vec_t v;
    v.is_d = is_d; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.kind = kind;
    v.exp_csb = exp_csb; v.exp_web = exp_web; v.exp_word = exp_word;
    return v;
  endfunction

  localparam int NV = 11;
  localparam int NR = 400;

  vec_t        tbl [NV];
  logic        grants [$];
  int          i_cnt, d_cnt;

  logic        exp_iv [NR+2];
  logic        exp_dv [NR+2];
  logic [31:0] exp_ir [NR+2];
  logic [31:0] exp_dr [NR+2];
  logic        exp_csb [NR+2];
  logic        exp_web [NR+2];
  logic [9:0]  exp_a [NR+2];
  logic [31:0] exp_din [NR+2];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] hold_i, hold_d, merged;
  logic [9:0]  widx;
  logic        d_wins_tie, want_i, want_d;
  int          free_at, wkind;

  initial begin
    // ---- reset state, with both requesters asking ----
    idle_inputs();
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_i_ready", 32'(i_req_ready), 32'd0);
    chk("rst_d_ready", 32'(d_req_ready), 32'd0);
    chk("rst_csb0", 32'(csb0), 32'd1);
    chk("rst_web0", 32'(web0), 32'd1);
    chk("rst_addr0", 32'(addr0), 32'd0);
    chk("rst_din0", din0, 32'd0);
    chk("rst_rsp_valid", {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
    chk("rst_rdata", i_rsp_rdata | d_rsp_rdata, 32'd0);
    do_reset();

    // ---- directed vector table ----
    tbl[0] = mk(1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF);
    tbl[1] = mk(0, 0, 4'hF, 32'h0000_0010, 32'h0,         1, 0, 1, 32'hDEAD_BEEF);
    tbl[2] = mk(0, 0, 4'hF, 32'h0000_1010, 32'h0,         1, 0, 1, 32'hDEAD_BEEF);
    tbl[3] = mk(1, 1, 4'hF, 32'h0000_0023, 32'h1122_3344, 0, 0, 0, 32'h1122_3344);
    tbl[4] = mk(1, 0, 4'h5, 32'h0000_0020, 32'h0,         1, 0, 1, 32'h1122_3344);
`ifdef SRAM_ARB_RMW_EN
    tbl[5] = mk(1, 1, 4'b0010, 32'h0000_0020, 32'h0000_AA00, 2, 0, 1, 32'h1122_AA44);
    tbl[6] = mk(0, 0, 4'hF,    32'h0000_0020, 32'h0,         1, 0, 1, 32'h1122_AA44);
    tbl[7] = mk(1, 1, 4'b0000, 32'h0000_0022, 32'hFFFF_FFFF, 0, 1, 1, 32'hFFFF_FFFF);
    tbl[8] = mk(1, 0, 4'hF,    32'h0000_0020, 32'h0,         1, 0, 1, 32'h1122_AA44);
`else
    tbl[5] = mk(1, 1, 4'b0010, 32'h0000_0020, 32'h0000_AA00, 0, 0, 0, 32'h0000_AA00);
    tbl[6] = mk(0, 0, 4'hF,    32'h0000_0020, 32'h0,         1, 0, 1, 32'h0000_AA00);
    tbl[7] = mk(1, 1, 4'b0000, 32'h0000_0022, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF);
    tbl[8] = mk(1, 0, 4'hF,    32'h0000_0020, 32'h0,         1, 0, 1, 32'hFFFF_FFFF);
`endif
    tbl[9]  = mk(1, 1, 4'hF, 32'hFFFF_FC10, 32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D);
    tbl[10] = mk(0, 0, 4'hF, 32'h0000_0C10, 32'h0,         1, 0, 1, 32'hCAFE_F00D);

    for (int v = 0; v < NV; v++) begin
      idle_inputs();
      if (tbl[v].is_d) begin
        d_req_valid = 1'b1; d_req_we = tbl[v].we; d_req_be = tbl[v].be;
        d_req_addr = tbl[v].addr; d_req_wdata = tbl[v].wdata;
      end else begin
        i_req_valid = 1'b1; i_req_addr = tbl[v].addr;
      end
      #1;
      chk($sformatf("v%0d_i_ready", v), 32'(i_req_ready), 32'(!tbl[v].is_d));
      chk($sformatf("v%0d_d_ready", v), 32'(d_req_ready), 32'(tbl[v].is_d));
      tick();
      // Scramble request inputs: the in-flight operation must not notice
      idle_inputs();
      d_req_addr = 32'h0000_03FC; d_req_wdata = 32'h5555_5555; i_req_addr = 32'h0000_03FC; d_req_be = 4'h0;
      chk($sformatf("v%0d_csb0", v), 32'(csb0), 32'(tbl[v].exp_csb));
      chk($sformatf("v%0d_web0", v), 32'(web0), 32'(tbl[v].exp_web));
      if (!tbl[v].exp_csb) chk($sformatf("v%0d_addr0", v), 32'(addr0), (tbl[v].addr >> 2) & 32'h3FF);
      if (tbl[v].kind == 0) begin
        if (!tbl[v].exp_csb) chk($sformatf("v%0d_din0", v), din0, tbl[v].exp_word);
        chk($sformatf("v%0d_d_rsp_valid", v), 32'(d_rsp_valid), 32'd1);
        chk($sformatf("v%0d_d_rsp_rdata", v), d_rsp_rdata, 32'd0);
        chk($sformatf("v%0d_i_rsp_valid", v), 32'(i_rsp_valid), 32'd0);
      end else begin
        chk($sformatf("v%0d_rsp_early", v), {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
        tick();
        if (tbl[v].kind == 2) begin
          chk($sformatf("v%0d_mrg_csb0", v), 32'(csb0), 32'd0);
          chk($sformatf("v%0d_mrg_web0", v), 32'(web0), 32'd0);
          chk($sformatf("v%0d_mrg_din0", v), din0, tbl[v].exp_word);
          chk($sformatf("v%0d_mrg_rsp", v), {30'd0, i_rsp_valid, d_rsp_valid}, 32'd1);
          chk($sformatf("v%0d_mrg_rdata", v), d_rsp_rdata, 32'd0);
        end else begin
          chk($sformatf("v%0d_rsp_csb0", v), 32'(csb0), 32'd1);
          chk($sformatf("v%0d_rsp_valid", v), {30'd0, i_rsp_valid, d_rsp_valid},
              tbl[v].is_d ? 32'd1 : 32'd2);
          chk($sformatf("v%0d_rsp_rdata", v), tbl[v].is_d ? d_rsp_rdata : i_rsp_rdata, tbl[v].exp_word);
        end
      end
      tick();
      chk($sformatf("v%0d_pulse_end", v), {30'd0, i_rsp_valid, d_rsp_valid}, 32'd0);
      chk($sformatf("v%0d_idle_csb0", v), 32'(csb0), 32'd1);
      if (tbl[v].kind == 1)
        chk($sformatf("v%0d_rdata_held", v), tbl[v].is_d ? d_rsp_rdata : i_rsp_rdata, tbl[v].exp_word);
    end

    // ---- contention: both valid held, reads from both ports ----
    do_reset();
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h20;
    i_cnt = 0; d_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 7) idle_inputs();
      #1;
      if (d_req_valid && d_req_ready) grants.push_back(1'b1);
      if (i_req_valid && i_req_ready) grants.push_back(1'b0);
      tick();
      i_cnt += int'(i_rsp_valid);
      d_cnt += int'(d_rsp_valid);
    end
    chk("rr_grant_count", 32'(grants.size()), 32'd3);
    if (grants.size() == 3) begin
      chk("rr_grant0_d", 32'(grants[0]), 32'd1);
      chk("rr_grant1_i", 32'(grants[1]), 32'd0);
      chk("rr_grant2_d", 32'(grants[2]), 32'd1);
    end
    chk("rr_i_rsp_count", 32'(i_cnt), 32'd1);
    chk("rr_d_rsp_count", 32'(d_cnt), 32'd2);
    chk("rr_i_rdata", i_rsp_rdata, 32'hDEAD_BEEF);

    // ---- reset during an in-flight fetch read ----
    do_reset();
    i_req_valid = 1'b1; i_req_addr = 32'h10;
    tick();
    i_req_valid = 1'b0;
    chk("mid_rd_csb0", 32'(csb0), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_csb0_async", 32'(csb0), 32'd1);
    chk("mid_rst_no_rsp", 32'(i_rsp_valid), 32'd0);
    i_req_valid = 1'b1;
    tick();
    chk("mid_rst_still_no_rsp", 32'(i_rsp_valid), 32'd0);
    chk("mid_rst_ready_low", 32'(i_req_ready), 32'd0);
    @(negedge clk0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(i_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0;
    chk("post_rst_csb0", 32'(csb0), 32'd0);
    chk("post_rst_addr0", 32'(addr0), 32'd4);
    tick();
    chk("post_rst_rsp", 32'(i_rsp_valid), 32'd1);
    chk("post_rst_rdata", i_rsp_rdata, 32'hDEAD_BEEF);
    tick();

    // ---- randomized run against a transaction-level model ----
    do_reset();
    for (int k = 0; k < 1024; k++) ref_mem[k] = '0;
    for (int e = 0; e < NR + 2; e++) begin
      exp_iv[e] = 0; exp_dv[e] = 0; exp_ir[e] = '0; exp_dr[e] = '0;
      exp_csb[e] = 1; exp_web[e] = 1; exp_a[e] = '0; exp_din[e] = '0;
    end
    free_at = 0; d_wins_tie = 1'b1; hold_i = '0; hold_d = '0;
    for (int e = 0; e < NR; e++) begin
      // Word indices 16..31 with random aliasing bits; untouched by the directed part
      i_req_valid = 1'($urandom_range(0, 1));
      i_req_addr  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(16, 31)) << 2);
      d_req_valid = 1'($urandom_range(0, 1));
      d_req_we    = 1'($urandom_range(0, 1));
      d_req_addr  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(16, 31)) << 2);
      d_req_wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       d_req_be = 4'hF;
        1:       d_req_be = 4'h0;
        default: d_req_be = 4'($urandom);
      endcase
      #1;
      want_d = (e >= free_at) && d_req_valid && (!i_req_valid || d_wins_tie);
      want_i = (e >= free_at) && i_req_valid && !want_d;
      chk("rnd_i_ready", 32'(i_req_ready), 32'(want_i));
      chk("rnd_d_ready", 32'(d_req_ready), 32'(want_d));
      if (want_d) begin
        d_wins_tie = 1'b0;
        widx = d_req_addr[11:2];
        exp_csb[e] = 1'b0; exp_a[e] = widx;
        if (!d_req_we) begin
          exp_dv[e+1] = 1'b1; exp_dr[e+1] = ref_mem[widx]; free_at = e + 3;
        end else begin
          wkind = 0;
`ifdef SRAM_ARB_RMW_EN
          if (d_req_be == 4'h0) wkind = 1;
          else if (d_req_be != 4'hF) wkind = 2;
`endif
          if (wkind == 0) begin
            exp_web[e] = 1'b0; exp_din[e] = d_req_wdata; ref_mem[widx] = d_req_wdata;
            exp_dv[e] = 1'b1; free_at = e + 2;
          end else if (wkind == 1) begin
            exp_csb[e] = 1'b1; exp_dv[e] = 1'b1; free_at = e + 2;
          end else begin
            merged = ref_mem[widx];
            for (int b = 0; b < 4; b++)
              if (d_req_be[b]) merged[b*8 +: 8] = d_req_wdata[b*8 +: 8];
            ref_mem[widx] = merged;
            exp_csb[e+1] = 1'b0; exp_web[e+1] = 1'b0; exp_a[e+1] = widx; exp_din[e+1] = merged;
            exp_dv[e+1] = 1'b1; free_at = e + 3;
          end
        end
      end else if (want_i) begin
        d_wins_tie = 1'b1;
        widx = i_req_addr[11:2];
        exp_csb[e] = 1'b0; exp_a[e] = widx;
        exp_iv[e+1] = 1'b1; exp_ir[e+1] = ref_mem[widx]; free_at = e + 3;
      end
      tick();
      if (exp_iv[e]) hold_i = exp_ir[e];
      if (exp_dv[e]) hold_d = exp_dr[e];
      chk("rnd_i_rsp_valid", 32'(i_rsp_valid), 32'(exp_iv[e]));
      chk("rnd_d_rsp_valid", 32'(d_rsp_valid), 32'(exp_dv[e]));
      chk("rnd_i_rsp_rdata", i_rsp_rdata, hold_i);
      chk("rnd_d_rsp_rdata", d_rsp_rdata, hold_d);
      chk("rnd_csb0", 32'(csb0), 32'(exp_csb[e]));
      chk("rnd_web0", 32'(web0), 32'(exp_web[e]));
      if (!exp_csb[e]) chk("rnd_addr0", 32'(addr0), 32'(exp_a[e]));
      if (!exp_web[e]) chk("rnd_din0", din0, exp_din[e]);
    end
    idle_inputs();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
